dmem_access_ctrl: RTL

- Memory-stage controller that sequences every access to the single-port data memory (32-bit words, registered 1-cycle read, synchronous write).
- Arbitrates the memory between the pipeline memory stage (CPU port) and an auxiliary loader/debug port (AUX, valid/ready).
- Performs byte/half stores as read-modify-write, sign/zero-extends loads, and stalls the pipeline while a multi-cycle access is in flight.

---
 rtl/dmem_access_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl
// Brief    : Data-memory sequencer: CPU/AUX arbitration, sub-word RMW stores,
//            load lane select and sign/zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int AUX_MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [1:0]            cpu_size,
  input  logic                  cpu_unsigned,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  cpu_misalign,
  input  logic                  aux_valid,
  output logic                  aux_ready,
  input  logic                  aux_we,
  input  logic [31:0]           aux_addr,
  input  logic [DATA_WIDTH-1:0] aux_wdata,
  output logic                  aux_rvalid,
  output logic [DATA_WIDTH-1:0] aux_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_RD  = 2'd1,
    CPU_RMW = 2'd2,
    AUX_RD  = 2'd3
  } state_t;

  localparam logic [7:0] c_max_wait = 8'(AUX_MAX_WAIT);
  localparam logic [7:0] c_wait_sat = 8'hFF;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [7:0]              r_wait_cnt;
  logic                    r_aux_rvalid;
  logic [DATA_WIDTH-1:0]   r_aux_rdata;

  logic [ADDR_WIDTH-1:0]   w_cpu_word;
  logic [ADDR_WIDTH-1:0]   w_aux_word;
  logic                    w_misalign;
  logic                    w_aux_win;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [DATA_WIDTH-1:0]   w_load_ext;
  logic [DATA_WIDTH-1:0]   w_merge;
  logic                    w_unused_bits;

  assign w_cpu_word = cpu_addr[ADDR_WIDTH+1:2];
  assign w_aux_word = aux_addr[ADDR_WIDTH+1:2];
  assign w_unused_bits = ^{cpu_addr[31:ADDR_WIDTH+2], aux_addr[31:ADDR_WIDTH+2], aux_addr[1:0]};

  assign w_misalign = (cpu_size == 2'b11)
                   || ((cpu_size == 2'b01) && cpu_addr[0])
                   || ((cpu_size == 2'b10) && (cpu_addr[1:0] != 2'b00));

  // AUX only preempts a pending CPU request once it has waited long enough
  assign w_aux_win = aux_valid && (!cpu_req || (r_wait_cnt >= c_max_wait));

  assign aux_rvalid = r_aux_rvalid;
  assign aux_rdata  = r_aux_rdata;

  always_comb begin
    w_byte     = 8'h00;
    w_load_ext = mem_rd;
    w_merge    = mem_rd;
    case (cpu_addr[1:0])
      2'd0:    w_byte = mem_rd[7:0];
      2'd1:    w_byte = mem_rd[15:8];
      2'd2:    w_byte = mem_rd[23:16];
      default: w_byte = mem_rd[31:24];
    endcase
    w_half = cpu_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (cpu_size)
      2'b00:   w_load_ext = {{24{w_byte[7] & ~cpu_unsigned}}, w_byte};
      2'b01:   w_load_ext = {{16{w_half[15] & ~cpu_unsigned}}, w_half};
      default: w_load_ext = mem_rd;
    endcase
    if (cpu_size == 2'b00) begin
      case (cpu_addr[1:0])
        2'd0:    w_merge[7:0]   = cpu_wdata[7:0];
        2'd1:    w_merge[15:8]  = cpu_wdata[7:0];
        2'd2:    w_merge[23:16] = cpu_wdata[7:0];
        default: w_merge[31:24] = cpu_wdata[7:0];
      endcase
    end else if (cpu_addr[1]) begin
      w_merge[31:16] = cpu_wdata[15:0];
    end else begin
      w_merge[15:0] = cpu_wdata[15:0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    mem_addr     = '0;
    mem_wd       = '0;
    mem_we       = 1'b0;
    cpu_stall    = 1'b0;
    cpu_misalign = 1'b0;
    cpu_rdata    = '0;
    aux_ready    = 1'b0;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (w_aux_win) begin
            aux_ready = 1'b1;
            mem_addr  = w_aux_word;
            cpu_stall = cpu_req;
            if (aux_we) begin
              mem_we = 1'b1;
              mem_wd = aux_wdata;
            end else begin
              w_state_next = AUX_RD;
            end
          end else if (cpu_req) begin
            if (w_misalign) begin
              cpu_misalign = 1'b1;
            end else begin
              mem_addr = w_cpu_word;
              if (!cpu_we) begin
                cpu_stall    = 1'b1;
                w_state_next = CPU_RD;
              end else if (cpu_size == 2'b10) begin
                mem_we = 1'b1;
                mem_wd = cpu_wdata;
              end else begin
                cpu_stall    = 1'b1;
                w_state_next = CPU_RMW;
              end
            end
          end
        end
        CPU_RD: begin
          mem_addr     = w_cpu_word;
          cpu_rdata    = w_load_ext;
          w_state_next = IDLE;
        end
        CPU_RMW: begin
          mem_addr     = w_cpu_word;
          mem_we       = 1'b1;
          mem_wd       = w_merge;
          w_state_next = IDLE;
        end
        AUX_RD: begin
          cpu_stall    = cpu_req;
          w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_wait_cnt   <= 8'h00;
      r_aux_rvalid <= 1'b0;
      r_aux_rdata  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_aux_rvalid <= (r_state == AUX_RD);
      if (r_state == AUX_RD) begin
        r_aux_rdata <= mem_rd;
      end
      if (aux_ready) begin
        r_wait_cnt <= 8'h00;
      end else if (aux_valid && (r_wait_cnt != c_wait_sat)) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire
